game_dumper: RTL and testbench
==============================

Name: game_dumper

Overview:
- Transmit-side counterpart of the cartridge loader: serialises the loaded game in SDRAM back out as an iNES byte stream.
- Output order: regenerated 16-byte header, then PRG ROM, then CHR ROM.
- Takes the loader's 32-bit mapper_flags word and reads memory through a request/acknowledge port.
- Drives a valid/ready byte stream into the UART/USB transmit path, used for cartridge dump and save-state export.

Parameters:
- CHR_BASE, 22'h200000: SDRAM byte address of CHR region.
- REFRESH_INTERVAL, 8: idle cycles between refresh pulses; range 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a dump; honoured only in IDLE or DONE
- mapper_flags  in  32  [7:0] mapper, [10:8] prg_size log2, [13:11] chr_size log2, [14] mirroring, [15] has_chr_ram; [31:16] ignored
- mem_addr  out  22  SDRAM byte address
- mem_rd  out  1  read request, held until mem_ack
- mem_ack  in  1  one-cycle read completion
- mem_rdata  in  8  read data, valid with mem_ack
- mem_refresh  out  1  one-cycle refresh request
- out_data  out  8  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts byte when out_valid && out_ready
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- bytes_left  out  22  remaining bytes in current region (debug)

Behaviour:
- Reset: state IDLE. All outputs 0. Refresh counter 0.
- start in IDLE/DONE:
  - latches mapper_flags;
  - prg_cnt = 1<<prg_size;
  - chr_cnt = has_chr_ram ? 0 : 1<<chr_size;
  - next cycle enters HDR with header index 0.
- start while busy: ignored.
- HDR state:
  - out_valid=1, out_data=hdr[idx].
  - Header bytes: 4E 45 53 1A, prg_cnt, chr_cnt, {mapper[3:0],3'b000,mirroring}, {mapper[7:4],4'b0000}, then 8 bytes 00.
  - Count bytes 4 and 5 wrap 128→... only prg_size/chr_size 7 yields 128 (fits 8 bits).
  - idx advances only on handshake.
  - Handshake at idx 15 → RD_REQ, mem_addr=0, bytes_left={prg_cnt,14'b0}.
- RD_REQ state:
  - mem_rd=1 with mem_addr stable until mem_ack.
  - mem_ack may arrive in the same cycle mem_rd first rises or any later cycle.
  - On mem_ack: capture mem_rdata, drop mem_rd next cycle, go SEND.
  - mem_ack outside RD_REQ: ignored.
- SEND state:
  - out_valid=1, out_data=captured byte, held stable until handshake.
  - On handshake: mem_addr+1, bytes_left−1.
  - If result bytes_left≠0 → RD_REQ.
  - Else if region PRG and chr_cnt≠0 → RD_REQ with mem_addr=CHR_BASE, bytes_left={1'b0,chr_cnt,13'b0}, region CHR.
  - Else → DONE.
- DONE state: done=1, out_valid=0. Sticky until start (restarts) or reset.
- Handshake rule: out_valid never drops without a handshake. Throughput at most one byte per read round trip; no prefetch.
- Refresh:
  - While busy and mem_rd=0, refresh counter increments.
  - At REFRESH_INTERVAL−1: mem_refresh=1 for one cycle, counter clears.
  - Refresh has priority: in a cycle where mem_refresh=1, mem_rd is held 0 (RD_REQ delays request one cycle).
  - Counter clears while mem_rd=1, and in IDLE/DONE. No refresh in IDLE/DONE.
- Widths:
  - bytes_left 22 bits; max PRG 2^21, max CHR 2^20.
  - mem_addr wraps modulo 2^22; unreachable with legal sizes.
- Reset mid-operation: immediate return to IDLE. Outstanding read abandoned; a late mem_ack is ignored.

Decomposition:
- Shared package (with loader):
  - mapper_flags field offsets/widths;
  - iNES magic bytes;
  - PRG bank shift 14, CHR bank shift 13;
  - CHR_BASE default.
- One natural sub-module, ines_header_gen: combinational header byte ROM from latched flags and idx.
- FSM, read port, and refresh counter stay in game_dumper.

Test Plan:
- Mapper 4, prg_size 1, chr_size 0, mirroring 1, has_chr_ram 0, ready tied 1, ack latency 3 → header 4E 45 53 1A 02 01 41 00 + 8×00. PRG addresses 0..0x7FFF, CHR 0x200000..0x201FFF. Total 40976 bytes matching memory model; done=1 after last byte.
- has_chr_ram 1, prg_size 0, mapper 0 → byte5=00, byte6=00/01; exactly 16+16384 bytes; no address ≥ CHR_BASE requested.
- Random out_ready backpressure (30% low) → out_data stable while out_valid && !out_ready; stream identical to unstalled run.
- ack latency 0 (combinational ack) and 20 → no dropped or duplicated byte. mem_rd falls the cycle after ack.
- Long stall (out_ready=0 for 40 cycles in SEND), REFRESH_INTERVAL 8 → mem_refresh pulses every 8 cycles, never coincident with mem_rd.
- reset asserted mid-PRG with ack pending, then start again → clean restart from header byte 4E; stale ack ignored. Second start during busy ignored.

Source files
------------

// File: rtl/game_dumper_pkg.sv
// Shared definitions for the cartridge loader and dumper: mapper_flags layout,
// iNES constants, SDRAM layout and the dumper FSM state type.
package game_dumper_pkg;

   localparam int MAPPER_LSB   = 0;
   localparam int MAPPER_W     = 8;
   localparam int PRG_SIZE_LSB = 8;
   localparam int PRG_SIZE_W   = 3;
   localparam int CHR_SIZE_LSB = 11;
   localparam int CHR_SIZE_W   = 3;
   localparam int MIRROR_BIT   = 14;
   localparam int CHR_RAM_BIT  = 15;

   localparam logic [31:0] INES_MAGIC       = 32'h4E45_531A;
   localparam int          PRG_BANK_SHIFT   = 14;
   localparam int          CHR_BANK_SHIFT   = 13;
   localparam logic [21:0] CHR_BASE_DEFAULT = 22'h200000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_RD_REQ,
      ST_SEND,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [MAPPER_W-1:0]   mapper;
      logic [PRG_SIZE_W-1:0] prg_size;
      logic [CHR_SIZE_W-1:0] chr_size;
      logic                  mirroring;
      logic                  has_chr_ram;
   } flags_t;

   function automatic flags_t decode_flags(input logic [15:0] w);
      flags_t f;
      f.mapper      = w[MAPPER_LSB +: MAPPER_W];
      f.prg_size    = w[PRG_SIZE_LSB +: PRG_SIZE_W];
      f.chr_size    = w[CHR_SIZE_LSB +: CHR_SIZE_W];
      f.mirroring   = w[MIRROR_BIT];
      f.has_chr_ram = w[CHR_RAM_BIT];
      return f;
   endfunction

   // Bank count in iNES units; size 7 gives 128, which still fits a byte.
   function automatic logic [7:0] bank_count(input logic [2:0] log2);
      return 8'd1 << log2;
   endfunction

endpackage

// File: rtl/game_dumper_if.sv
// Memory read port and outgoing byte stream of the game dumper.
interface game_dumper_if;
   // A byte moves on a rising edge with out_valid && out_ready; once out_valid
   // is high, out_data holds until that edge. mem_rd holds mem_addr until a
   // cycle with mem_ack, which may coincide with the first mem_rd cycle.
   logic [21:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        mem_refresh;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output mem_addr, mem_rd, mem_refresh, out_data, out_valid,
      input  mem_ack, mem_rdata, out_ready
   );

   modport slave (
      input  mem_addr, mem_rd, mem_refresh, out_data, out_valid,
      output mem_ack, mem_rdata, out_ready
   );
endinterface

// File: rtl/game_dumper_ines_header_gen.sv
// Combinational 16-byte iNES header ROM built from the latched cartridge flags.
module game_dumper_ines_header_gen
   import game_dumper_pkg::*;
(
   input  logic [7:0] mapper,
   input  logic       mirroring,
   input  logic [7:0] prg_cnt,
   input  logic [7:0] chr_cnt,
   input  logic [3:0] idx,
   output logic [7:0] hdr_byte
);

   always_comb begin
      hdr_byte = 8'h00;
      case (idx)
         4'd0:    hdr_byte = INES_MAGIC[31:24];
         4'd1:    hdr_byte = INES_MAGIC[23:16];
         4'd2:    hdr_byte = INES_MAGIC[15:8];
         4'd3:    hdr_byte = INES_MAGIC[7:0];
         4'd4:    hdr_byte = prg_cnt;
         4'd5:    hdr_byte = chr_cnt;
         4'd6:    hdr_byte = {mapper[3:0], 3'b000, mirroring};
         4'd7:    hdr_byte = {mapper[7:4], 4'b0000};
         default: hdr_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/game_dumper.sv
// Streams the loaded game out of SDRAM as an iNES image: header, PRG, CHR.
// One read per byte, no prefetch; refresh is slotted into gaps between reads.
module game_dumper
   import game_dumper_pkg::*;
#(
   parameter logic [21:0] CHR_BASE         = CHR_BASE_DEFAULT,
   parameter int unsigned REFRESH_INTERVAL = 8
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          mapper_flags,
   game_dumper_if.master        bus,
   output logic                 busy,
   output logic                 done,
   output logic [21:0]          bytes_left,
   output state_t               state_dbg
);

   localparam logic [7:0] REFRESH_LAST = 8'(REFRESH_INTERVAL - 1);

   state_t      state_q, state_d;
   flags_t      flags_in;
   logic [7:0]  mapper_q;
   logic        mirror_q;
   logic [7:0]  prg_cnt_q, chr_cnt_q;
   logic [3:0]  hdr_idx_q;
   logic [21:0] addr_q, left_q, left_dec;
   logic [7:0]  data_q, hdr_byte, ref_cnt_q;
   logic        region_chr_q, active, refresh_now, rd_req, rd_done;

   wire unused_flags = ^mapper_flags[31:16];

   assign flags_in    = decode_flags(mapper_flags[15:0]);
   assign active      = (state_q == ST_HDR) || (state_q == ST_RD_REQ) || (state_q == ST_SEND);
   assign refresh_now = active && (ref_cnt_q == REFRESH_LAST);
   // Refresh wins the cycle; the read request simply starts one cycle later.
   assign rd_req      = (state_q == ST_RD_REQ) && !refresh_now;
   assign rd_done     = rd_req && bus.mem_ack;
   assign left_dec    = left_q - 22'd1;

   assign bus.mem_addr = addr_q;
   assign bytes_left   = left_q;
   assign state_dbg    = state_q;

   game_dumper_ines_header_gen u_hdr (
      .mapper    (mapper_q),
      .mirroring (mirror_q),
      .prg_cnt   (prg_cnt_q),
      .chr_cnt   (chr_cnt_q),
      .idx       (hdr_idx_q),
      .hdr_byte  (hdr_byte)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      busy            = active;
      done            = (state_q == ST_DONE);
      bus.out_valid   = 1'b0;
      bus.out_data    = 8'h00;
      bus.mem_rd      = rd_req;
      bus.mem_refresh = refresh_now;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_HDR;
         ST_HDR: begin
            bus.out_valid = 1'b1;
            bus.out_data  = hdr_byte;
            if (bus.out_ready && hdr_idx_q == 4'd15) state_d = ST_RD_REQ;
         end
         ST_RD_REQ: if (rd_done) state_d = ST_SEND;
         ST_SEND: begin
            bus.out_valid = 1'b1;
            bus.out_data  = data_q;
            if (bus.out_ready) begin
               if (left_dec != 22'd0)                     state_d = ST_RD_REQ;
               else if (!region_chr_q && chr_cnt_q != 0)  state_d = ST_RD_REQ;
               else                                       state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mapper_q     <= '0;
         mirror_q     <= 1'b0;
         prg_cnt_q    <= '0;
         chr_cnt_q    <= '0;
         hdr_idx_q    <= '0;
         addr_q       <= '0;
         left_q       <= '0;
         data_q       <= '0;
         region_chr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (start) begin
               mapper_q  <= flags_in.mapper;
               mirror_q  <= flags_in.mirroring;
               prg_cnt_q <= bank_count(flags_in.prg_size);
               chr_cnt_q <= flags_in.has_chr_ram ? 8'd0 : bank_count(flags_in.chr_size);
               hdr_idx_q <= '0;
            end
            ST_HDR: if (bus.out_ready) begin
               hdr_idx_q <= hdr_idx_q + 4'd1;
               if (hdr_idx_q == 4'd15) begin
                  addr_q       <= '0;
                  left_q       <= 22'(prg_cnt_q) << PRG_BANK_SHIFT;
                  region_chr_q <= 1'b0;
               end
            end
            ST_RD_REQ: if (rd_done) data_q <= bus.mem_rdata;
            ST_SEND: if (bus.out_ready) begin
               if (left_dec == 22'd0 && !region_chr_q && chr_cnt_q != 0) begin
                  addr_q       <= CHR_BASE;
                  left_q       <= 22'(chr_cnt_q) << CHR_BANK_SHIFT;
                  region_chr_q <= 1'b1;
               end else begin
                  addr_q <= addr_q + 22'd1;
                  left_q <= left_dec;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !active || refresh_now || rd_req) ref_cnt_q <= '0;
      else                                           ref_cnt_q <= ref_cnt_q + 8'd1;
   end

endmodule

// File: tb/tb_game_dumper.sv
// Directed bench for game_dumper: memory model with programmable ack latency,
// expected-byte/address queues checked by a negedge monitor.
module tb_game_dumper;
   import game_dumper_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] mapper_flags;
   logic        busy, done;
   logic [21:0] bytes_left;
   state_t      state_dbg;

   game_dumper_if bus ();

   game_dumper #(.CHR_BASE(22'h200000), .REFRESH_INTERVAL(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mapper_flags (mapper_flags),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .bytes_left   (bytes_left),
      .state_dbg    (state_dbg)
   );

   initial forever #5 clk = ~clk;

   int          errors = 0, checks = 0, n_bytes = 0;
   int          ack_lat = 0, lat_cnt = 0, ready_mode = 0;
   logic        stale_ack = 1'b0;
   logic [7:0]  exp_q[$];
   logic [21:0] addr_q[$];
   logic        prev_stall = 1'b0, prev_ack = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   localparam logic [127:0] HDR1 = 128'h4E45531A_01014100_00000000_00000000;
   localparam logic [127:0] HDR2 = 128'h4E45531A_01000100_00000000_00000000;
   localparam logic [127:0] HDR3 = 128'h4E45531A_808070A0_00000000_00000000;
   localparam logic [127:0] HDR5 = 128'h4E45531A_01011000_00000000_00000000;

   function automatic logic [7:0] mem_byte(input logic [21:0] a);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
   endfunction

   // Memory model: ack once mem_rd has been seen for ack_lat earlier cycles.
   always @(posedge clk) begin
      if (reset || !bus.mem_rd || bus.mem_ack) lat_cnt <= 0;
      else                                     lat_cnt <= lat_cnt + 1;
   end
   assign bus.mem_ack   = (bus.mem_rd && lat_cnt >= ack_lat) || stale_ack;
   assign bus.mem_rdata = mem_byte(bus.mem_addr);

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 99) >= 30);
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_stall) check("out_hold", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, prev_data});
         if (prev_ack) check("rd_drop", 32'(bus.mem_rd), 32'd0);
         if (bus.mem_refresh) check("refresh_vs_rd", 32'(bus.mem_rd), 32'd0);
         if (bus.mem_rd && bus.mem_ack) begin
            if (addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_addr: unexpected read at %0h", bus.mem_addr);
            end else check("rd_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL stream_byte: extra byte %0h", bus.out_data);
            end else check("stream_byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
            n_bytes++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_ack   = bus.mem_rd && bus.mem_ack;
      end else begin
         prev_stall = 1'b0;
         prev_ack   = 1'b0;
      end
   end

   task automatic push_stream(input logic [127:0] hdr, input int prg_n, input int chr_n, input int max_data);
      int n = 0;
      for (int i = 0; i < 16; i++) exp_q.push_back(hdr[127-8*i -: 8]);
      for (int a = 0; a < prg_n && n < max_data; a++) begin
         addr_q.push_back(22'(a));
         exp_q.push_back(mem_byte(22'(a)));
         n++;
      end
      for (int a = 0; a < chr_n && n < max_data; a++) begin
         addr_q.push_back(22'h200000 + 22'(a));
         exp_q.push_back(mem_byte(22'h200000 + 22'(a)));
         n++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete(); addr_q.delete();
      n_bytes = 0;
      reset = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] f);
      @(posedge clk); #1;
      mapper_flags = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},     32'(busy),            32'd0);
      check({tag, "_done"},     32'(done),            32'd0);
      check({tag, "_valid"},    32'(bus.out_valid),   32'd0);
      check({tag, "_data"},     32'(bus.out_data),    32'd0);
      check({tag, "_rd"},       32'(bus.mem_rd),      32'd0);
      check({tag, "_refresh"},  32'(bus.mem_refresh), 32'd0);
      check({tag, "_addr"},     32'(bus.mem_addr),    32'd0);
      check({tag, "_left"},     32'(bytes_left),      32'd0);
      check({tag, "_state"},    32'(state_dbg),       32'(ST_IDLE));
   endtask

   task automatic wait_state(input state_t s, input int budget);
      int n = 0;
      while (state_dbg !== s && n < budget) begin @(negedge clk); n++; end
      if (state_dbg !== s) begin
         checks++; errors++;
         $display("FAIL wait_state: state %0d, wanted %0d within %0d cycles", state_dbg, s, budget);
      end
   endtask

   task automatic wait_bytes(input int target, input int budget);
      int n = 0;
      while (n_bytes < target && n < budget) begin @(negedge clk); n++; end
      if (n_bytes < target) begin
         checks++; errors++;
         $display("FAIL wait_bytes: got %0d bytes, wanted %0d within %0d cycles", n_bytes, target, budget);
      end
   endtask

   initial begin
      int n, cnt, last;
      reset = 1'b1; start = 1'b0; mapper_flags = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle("reset");

      // Full dump: mapper 4, 16K PRG, 8K CHR, vertical mirroring, combinational ack.
      ack_lat = 0; ready_mode = 0;
      push_stream(HDR1, 16384, 8192, 1 << 30);
      pulse_start(32'hABCD_4004);
      n = 0;
      while (!done && n < 60000) begin @(negedge clk); n++; end
      check("full_done",     32'(done),          32'd1);
      check("full_busy",     32'(busy),          32'd0);
      check("full_valid",    32'(bus.out_valid), 32'd0);
      check("full_count",    32'(n_bytes),       32'd24592);
      check("full_exp_left", 32'(exp_q.size()),  32'd0);
      check("full_addr_left",32'(addr_q.size()), 32'd0);

      // CHR RAM cartridge, restarted straight from DONE.
      ack_lat = 1; n_bytes = 0;
      push_stream(HDR2, 16384, 0, 64);
      pulse_start(32'h0000_D800);
      wait_state(ST_RD_REQ, 100);
      check("chrram_prg_left", 32'(bytes_left), 32'h4000);
      wait_bytes(56, 500);
      do_reset();
      @(negedge clk);
      check_idle("rst2");

      // Largest sizes (128 banks each), latency 3, random backpressure.
      ack_lat = 3; ready_mode = 1;
      push_stream(HDR3, 1 << 21, 1 << 20, 400);
      pulse_start(32'h0000_3FA7);
      wait_state(ST_RD_REQ, 200);
      check("max_prg_left", 32'(bytes_left), 32'h200000);
      wait_bytes(316, 6000);
      do_reset();

      // Long sink stall in SEND: refresh every 8 cycles.
      ack_lat = 2; ready_mode = 0;
      push_stream(HDR1, 16384, 8192, 200);
      pulse_start(32'h0000_4004);
      wait_bytes(20, 500);
      ready_mode = 2;
      repeat (12) @(negedge clk);
      check("stall_state", 32'(state_dbg), 32'(ST_SEND));
      cnt = 0; last = -1;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         if (bus.mem_refresh) begin
            if (last >= 0) check("refresh_gap", 32'(c - last), 32'd8);
            last = c; cnt++;
         end
      end
      check("refresh_count", 32'(cnt), 32'd6);
      ready_mode = 0;
      wait_bytes(80, 1000);
      do_reset();

      // Latency 20; reset while a read is outstanding, then a stale ack.
      ack_lat = 20; ready_mode = 0;
      push_stream(HDR5, 16384, 8192, 100);
      pulse_start(32'h0000_0001);
      wait_bytes(19, 500);
      n = 0;
      while (!(bus.mem_rd && lat_cnt >= 5) && n < 100) begin @(negedge clk); n++; end
      check("pending_rd", 32'(bus.mem_rd), 32'd1);
      do_reset();
      @(posedge clk); #1 stale_ack = 1'b1;
      @(posedge clk); #1 stale_ack = 1'b0;
      @(negedge clk);
      check_idle("rst5");

      ack_lat = 0;
      push_stream(HDR1, 16384, 8192, 50);
      pulse_start(32'h0000_4004);
      wait_bytes(5, 100);
      pulse_start(32'h0000_3FA7);
      @(posedge clk); #1 stale_ack = 1'b1;
      @(posedge clk); #1 stale_ack = 1'b0;
      wait_bytes(46, 500);
      check("restart_busy", 32'(busy), 32'd1);
      do_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
